// File: rtl/tlc_pkg.sv
// tlc_pkg: shared register map, mode/state encodings and phase-load helpers
package tlc_pkg;
  localparam logic [31:0] A_RED = 32'h00;
  localparam logic [31:0] A_YELLOW = 32'h04;
  localparam logic [31:0] A_GREEN = 32'h08;
  localparam logic [31:0] A_MODE = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [2:0] MODE_LOW = 3'b100;
  localparam logic [2:0] MODE_HIGH = 3'b011;
  localparam logic [2:0] MODE_BLINK = 3'b001;
  localparam logic [2:0] ST_RED = 3'b100;
  localparam logic [2:0] ST_YELLOW = 3'b010;
  localparam logic [2:0] ST_GREEN = 3'b001;
  localparam logic [2:0] ST_OFF = 3'b000;
  typedef enum logic [1:0] {OP_STOP, OP_RUN, OP_BLINK} op_t;
  function automatic op_t op_of(input logic [2:0] m);
    return (m == MODE_LOW || m == MODE_HIGH) ? OP_RUN : (m == MODE_BLINK) ? OP_BLINK : OP_STOP;
  endfunction
  // a zero duration still lasts one cycle, so the counter reload is max(n,1)-1
  function automatic logic [15:0] load_val(input logic [31:0] r, input logic hi);
    logic [15:0] n;
    n = hi ? r[31:16] : r[15:0];
    return (n == 16'd0) ? 16'd0 : n - 16'd1;
  endfunction
endpackage

// File: rtl/tlc_if.sv
// tlc_if: valid/ready register bus between the system master and the controller
interface tlc_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic prd_wr;
  logic pvalid;
  logic pready;
  modport master(output paddr, pwdata, prd_wr, pvalid, input prdata, pready);
  modport slave(input paddr, pwdata, prd_wr, pvalid, output prdata, pready);
endinterface

// File: rtl/tlc_regs.sv
// tlc_regs: bus handshake, duration/mode register file and registered read mux
module tlc_regs
  import tlc_pkg::*;
(
  input  logic        pclk,
  input  logic        prst,
  tlc_if.slave        bus,
  input  logic [2:0]  state,
  input  logic [15:0] count,
  output logic [31:0] red,
  output logic [31:0] yellow,
  output logic [31:0] green,
  output logic [2:0]  mode
);
  logic xfer;
  logic [31:0] rmux;
  assign xfer = bus.pvalid & ~bus.pready;
  always_comb begin
    rmux = (bus.paddr == A_RED) ? red :
           (bus.paddr == A_YELLOW) ? yellow :
           (bus.paddr == A_GREEN) ? green :
           (bus.paddr == A_MODE) ? {29'd0, mode} :
           (bus.paddr == A_STATUS) ? {13'd0, state, count} : 32'd0;
  end
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      bus.pready <= 1'b0;
      bus.prdata <= 32'd0;
      red <= 32'd0;
      yellow <= 32'd0;
      green <= 32'd0;
      mode <= 3'd0;
    end else begin
      bus.pready <= xfer;
      if (xfer && !bus.prd_wr) bus.prdata <= rmux;
      if (xfer && bus.prd_wr && bus.paddr == A_RED) red <= bus.pwdata;
      if (xfer && bus.prd_wr && bus.paddr == A_YELLOW) yellow <= bus.pwdata;
      if (xfer && bus.prd_wr && bus.paddr == A_GREEN) green <= bus.pwdata;
      if (xfer && bus.prd_wr && bus.paddr == A_MODE) mode <= bus.pwdata[2:0];
    end
  end
endmodule

// File: rtl/tlc_ctrl.sv
// tlc_ctrl: traffic light controller; register file plus phase FSM and down-counter
module tlc_ctrl
  import tlc_pkg::*;
(
  input  logic       pclk,
  input  logic       prst,
  tlc_if.slave       bus,
  output logic [2:0] state
);
  logic [31:0] red, yellow, green;
  logic [2:0] mode, nstate;
  logic [15:0] count, ncount;
  op_t op, op_q;
  logic hi;
  tlc_regs u_regs (
    .pclk(pclk), .prst(prst), .bus(bus), .state(state), .count(count),
    .red(red), .yellow(yellow), .green(green), .mode(mode)
  );
  assign op = op_of(mode);
  assign hi = mode == MODE_HIGH;
  // a change of operating class overrides any phase expiry on the same cycle;
  // low<->high stays in class and is picked up at the next reload
  always_comb begin
    nstate = state;
    ncount = count;
    if (op != op_q) begin
      nstate = (op == OP_STOP) ? ST_RED : (op == OP_BLINK) ? ST_YELLOW : (op_q == OP_BLINK) ? ST_RED : ST_GREEN;
      ncount = (op == OP_STOP) ? 16'd0 : (op == OP_BLINK) ? load_val(yellow, 1'b0) :
               load_val((op_q == OP_BLINK) ? red : green, hi);
    end else if (op == OP_STOP) begin
      nstate = ST_RED;
      ncount = 16'd0;
    end else if (count != 16'd0) begin
      ncount = count - 16'd1;
    end else if (op == OP_BLINK) begin
      nstate = (state == ST_YELLOW) ? ST_OFF : ST_YELLOW;
      ncount = load_val(yellow, 1'b0);
    end else begin
      nstate = (state == ST_GREEN) ? ST_YELLOW : (state == ST_YELLOW) ? ST_RED : ST_GREEN;
      ncount = load_val((state == ST_GREEN) ? yellow : (state == ST_YELLOW) ? red : green, hi);
    end
  end
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state <= ST_RED;
      count <= 16'd0;
      op_q <= OP_STOP;
    end else begin
      state <= nstate;
      count <= ncount;
      op_q <= op;
    end
  end
endmodule

// File: tb/tb_tlc_ctrl.sv
// tb_tlc_ctrl: directed checks of bus access, phase timing, blink, stop and reset
module tb_tlc_ctrl;
  logic pclk = 1'b0;
  logic prst = 1'b0;
  logic [2:0] state;
  logic [31:0] rd;
  logic [2:0] st;
  int len, n_cmp = 0, n_bad = 0, bad;
  tlc_if bus();
  tlc_ctrl dut (.pclk(pclk), .prst(prst), .bus(bus), .state(state));
  always #5 pclk = ~pclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic wr, output logic [31:0] r);
    int k;
    bus.paddr = a;
    bus.pwdata = d;
    bus.prd_wr = wr;
    bus.pvalid = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(posedge pclk);
      #1;
      if (bus.pready) break;
    end
    if (k >= 10) check("pready_timeout", {31'd0, bus.pready}, 32'd1);
    @(negedge pclk);
    bus.pvalid = 1'b0;
    r = bus.prdata;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    xfer(a, d, 1'b1, x);
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    xfer(a, 32'd0, 1'b0, x);
    check(tag, x, exp);
  endtask
  task automatic measure(output logic [2:0] s, output int n);
    s = state;
    n = 1;
    while (n < 400) begin
      @(negedge pclk);
      if (state !== s) break;
      n++;
    end
  endtask
  task automatic phase_chk(input string tag, input logic [2:0] es, input int en);
    logic [2:0] s;
    int n;
    measure(s, n);
    check({tag, "_state"}, {29'd0, s}, {29'd0, es});
    check({tag, "_len"}, n, en);
  endtask
  task automatic sync(input string tag);
    logic [2:0] s;
    int i;
    s = state;
    for (i = 0; i < 400 && state === s; i++) @(negedge pclk);
    if (i >= 400) check({tag, "_timeout"}, {29'd0, state}, {29'd0, ~s});
  endtask
  initial begin
    bus.paddr = 0;
    bus.pwdata = 0;
    bus.prd_wr = 0;
    bus.pvalid = 0;
    repeat (2) @(negedge pclk);
    check("rst_state", {29'd0, state}, 32'h4);
    check("rst_pready", {31'd0, bus.pready}, 32'd0);
    check("rst_prdata", bus.prdata, 32'd0);
    prst = 1'b1;
    @(negedge pclk);
    rd_chk("rst_red", 32'h00, 32'd0);
    rd_chk("rst_yellow", 32'h04, 32'd0);
    rd_chk("rst_green", 32'h08, 32'd0);
    rd_chk("rst_mode", 32'h0C, 32'd0);
    rd_chk("rst_status", 32'h10, 32'h00040000);
    wr(32'h00, 32'h0064001E);
    wr(32'h04, 32'h001E0005);
    wr(32'h08, 32'h00500019);
    wr(32'h10, 32'hFFFFFFFF);
    rd_chk("rd_red", 32'h00, 32'h0064001E);
    rd_chk("rd_yellow", 32'h04, 32'h001E0005);
    rd_chk("rd_green", 32'h08, 32'h00500019);
    rd_chk("rd_unmapped", 32'h14, 32'd0);
    rd_chk("ro_status", 32'h10, 32'h00040000);
    wr(32'h0C, 32'hFFFFFFFC);
    sync("low_start");
    phase_chk("low_g", 3'b001, 25);
    phase_chk("low_y", 3'b010, 5);
    phase_chk("low_r", 3'b100, 30);
    check("low_g2_state", {29'd0, state}, 32'h1);
    rd_chk("status_1", 32'h10, 32'h00010018);
    rd_chk("status_2", 32'h10, 32'h00010016);
    rd_chk("rd_mode_low", 32'h0C, 32'h4);
    wr(32'h0C, 32'h3);
    sync("high_start");
    phase_chk("high_y", 3'b010, 30);
    phase_chk("high_r", 3'b100, 100);
    phase_chk("high_g", 3'b001, 80);
    wr(32'h0C, 32'h1);
    @(negedge pclk);
    phase_chk("blink_on", 3'b010, 5);
    phase_chk("blink_off", 3'b000, 5);
    phase_chk("blink_on2", 3'b010, 5);
    wr(32'h0C, 32'h0);
    @(negedge pclk);
    check("stop_state", {29'd0, state}, 32'h4);
    bad = 0;
    repeat (50) begin
      @(negedge pclk);
      if (state !== 3'b100) bad++;
    end
    check("stop_steady", bad, 0);
    rd_chk("stop_status", 32'h10, 32'h00040000);
    wr(32'h0C, 32'h3);
    sync("hr_start");
    check("hr_green", {29'd0, state}, 32'h1);
    for (int i = 0; i < 500 && state !== 3'b100; i++) @(negedge pclk);
    check("hr_in_red", {29'd0, state}, 32'h4);
    repeat (10) @(negedge pclk);
    #2 prst = 1'b0;
    #1;
    check("mid_rst_state", {29'd0, state}, 32'h4);
    check("mid_rst_pready", {31'd0, bus.pready}, 32'd0);
    @(negedge pclk);
    prst = 1'b1;
    rd_chk("mid_rst_mode", 32'h0C, 32'd0);
    rd_chk("mid_rst_red", 32'h00, 32'd0);
    rd_chk("mid_rst_status", 32'h10, 32'h00040000);
    bad = 0;
    repeat (100) begin
      @(negedge pclk);
      if (state !== 3'b100) bad++;
    end
    check("mid_rst_idle", bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlc_ctrl.md
Name: tlc_ctrl

Overview:
- Traffic light controller with a simple valid/ready register bus.
- Software programs red, yellow and green phase durations (high-traffic and low-traffic values) plus an operating mode.
- The controller sequences a 3-bit one-hot light output.
- Sits behind the system register bus; `state` drives the lamp drivers.

Parameters:
- none (all widths fixed: bus 32 bits, durations 16 bits, state 3 bits)

Ports:
- pclk  input  1  clock; all logic on rising edge
- prst  input  1  reset; asynchronous, active-low
- paddr  input  32  register byte address
- pwdata  input  32  write data
- prd_wr  input  1  1 = write, 0 = read
- pvalid  input  1  transfer request
- prdata  output  32  read data; registered, held until next read completes
- pready  output  1  transfer-complete pulse
- state  output  3  lights {red, yellow, green}; one-hot, 000 = all off

Behaviour:
- Reset (prst=0, asynchronous):
  - all registers = 0, mode = 000
  - prdata = 0, pready = 0, state = 100 (RED), phase counter = 0
- Handshake:
  - pready <= pvalid & ~pready, so it is a one-cycle pulse one clock after pvalid is sampled high.
  - Back-to-back pvalid gives alternating request/ready cycles.
  - On the edge where pready rises:
    - A write updates the addressed register.
    - A read loads prdata. prdata then holds until the next read, so a sample one cycle after pready sees valid data.
  - Master drops pvalid once it sees pready.
- Register map (full 32-bit address compare):
  - 0x00 RED (RW): [31:16] high-traffic cycles, [15:0] low-traffic cycles.
  - 0x04 YELLOW (RW): same split.
  - 0x08 GREEN (RW): same split.
  - 0x0C MODE (RW): [2:0] only; [31:3] write-ignored, read 0.
    - 100 = low traffic
    - 011 = high traffic
    - 001 = blink
    - any other value = STOP
  - 0x10 STATUS (RO): {13'b0, state[2:0], count[15:0]}. Writes ignored.
  - Any other address: write ignored, read returns 0, pready still pulses.
- Phase timing:
  - On phase entry, count loads max(N,1)-1. N is the selected 16-bit field: [15:0] in low mode, [31:16] in high mode.
  - count decrements each cycle.
  - The transition occurs on the cycle count==0, so each phase lasts exactly max(N,1) cycles.
- Run modes (low/high): GREEN(001) -> YELLOW(010) -> RED(100) -> GREEN.
  - Duration register writes and low<->high mode switches take effect at the next phase load; the current phase completes with its loaded count.
- STOP: state = 100 steady, count = 0.
  - STOP -> run mode: next cycle enters GREEN with a fresh load.
- Blink: state alternates 010 / 000, each half lasting max(YELLOW[15:0],1) cycles.
  - Entering blink from any mode: next cycle state = 010 with a fresh load.
  - Blink -> run mode: next cycle enters RED with a fresh load.
  - Run/blink -> STOP: next cycle RED steady.
- Mode written and phase expiring on the same edge: the mode change wins.
- Reset mid-operation: immediate return to reset values, including mode = STOP.

Decomposition:
- Shared package tlc_pkg holds:
  - register address constants (0x00..0x10)
  - mode encodings (100, 011, 001)
  - state encodings (RED 100, YELLOW 010, GREEN 001, OFF 000)
- Natural split: sub-module tlc_regs (bus handshake, register file, read mux).
- Top instantiates tlc_regs plus the phase FSM/counter.

Test Plan:
- Reset: hold prst=0 two cycles -> state=100, pready=0, prdata=0, all registers read 0 afterwards.
- Writes/reads:
  - Write 0x00={100,30}, 0x04={30,5}, 0x08={80,25}.
  - Read back each; prdata one cycle after pready = 0x0064001E, 0x001E0005, 0x00500019.
  - Read 0x14 returns 0.
- Low mode: write 0x0C=4 -> GREEN 25 cycles, YELLOW 5, RED 30, GREEN again (period 60); read 0x0C = 4; STATUS count decrements.
- High mode: write 0x0C=3 mid-green -> current phase completes, then YELLOW 30, RED 100, GREEN 80.
- Blink: write 0x0C=1 -> next cycle state=010 for 5 cycles, 000 for 5, repeating. Then write 0x0C=0 -> state=100 steady.
- Reset mid-RED in high mode -> state=100 immediately, mode reads 0, no sequencing until the mode is rewritten.
